spi_fifo_feeder: RTL and testbench

Parametrised stream source that replays a preloaded word buffer into the SPI write-path TX FIFO for bench and bring-up tests. It extends the fixed 8-bit, fixed-length filler: width, depth, start address and length are configurable, FIFO backpressure is honoured, single-shot and repeat modes are supported, and the buffer can be rewritten at runtime between runs. It sits between the test controller (start/config/load) and the TX FIFO write port.

---
 rtl/spi_fifo_feeder.sv | 98 +++++++++
 tb/tb_spi_fifo_feeder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_fifo_feeder.sv
// spi_fifo_feeder: replays a preloaded word buffer into a TX FIFO, single-shot or repeating, honouring backpressure.
module spi_fifo_feeder #(
  parameter int    DATA_W    = 8,
  parameter int    DEPTH     = 2048,
  parameter int    ADDR_W    = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              cfg_repeat,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_sent,
  output logic [15:0]       pass_cnt
);
  typedef enum logic [1:0] {IDLE, PREFETCH, PASS, DONE} state_t;
  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_base, r_ptr;
  logic [ADDR_W:0]   r_len, r_sent;
  logic [15:0]       r_pass;
  logic              r_start_q, r_rep;
  logic              w_idle, w_edge, w_wr, w_last;
  logic [ADDR_W-1:0] w_nxt;

  always_comb begin
    w_idle = (r_state == IDLE) || (r_state == DONE);
    w_edge = start && !r_start_q;
    w_wr   = (r_state == PASS) && !fifo_full && !abort && !rst;
    w_nxt  = r_ptr + 1'b1;
    w_last = (r_sent + 1'b1) == r_len;
  end

  always_ff @(posedge clk)
    if (ld_en && w_idle) r_mem[ld_addr] <= ld_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      r_data    <= '0;
      r_base    <= '0;
      r_ptr     <= '0;
      r_len     <= '0;
      r_sent    <= '0;
      r_pass    <= '0;
      r_rep     <= 1'b0;
    end else begin
      r_start_q <= start;
      if (abort) r_state <= IDLE;
      else case (r_state)
        IDLE, DONE: if (w_edge) begin
          r_base  <= cfg_base;
          r_ptr   <= cfg_base;
          r_len   <= (cfg_len == '0) ? (ADDR_W+1)'(DEPTH) : cfg_len;
          r_rep   <= cfg_repeat;
          r_sent  <= '0;
          r_pass  <= '0;
          r_state <= PREFETCH;
        end
        PREFETCH: begin
          r_data  <= r_mem[r_ptr];
          r_state <= PASS;
        end
        PASS: if (w_wr) begin
          r_data <= r_mem[w_nxt];
          r_ptr  <= w_last ? r_base : w_nxt;
          r_sent <= w_last ? '0 : r_sent + 1'b1;
          if (w_last) begin
            r_pass  <= r_pass + 1'b1;
            r_state <= r_rep ? PREFETCH : DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_wr_en = w_wr;
    fifo_data  = r_data;
    busy       = (r_state == PREFETCH) || (r_state == PASS);
    done       = r_state == DONE;
    words_sent = r_sent;
    pass_cnt   = r_pass;
  end
endmodule

// File: tb/tb_spi_fifo_feeder.sv
// tb_spi_fifo_feeder: directed scenario tests for spi_fifo_feeder with a 16-word buffer.
module tb_spi_fifo_feeder;
  logic       clk = 0, rst = 1, start = 0, abort = 0, cfg_repeat = 0;
  logic       ld_en = 0, fifo_full = 0;
  logic [3:0] cfg_base = 0, ld_addr = 0;
  logic [4:0] cfg_len = 0;
  logic [7:0] ld_data = 0;
  logic       fifo_wr_en, busy, done;
  logic [7:0] fifo_data;
  logic [4:0] words_sent;
  logic [15:0] pass_cnt;
  int n_chk = 0, n_fail = 0, cyc = 0, c0 = 0;
  logic [7:0] wd[$];
  int wc[$];

  spi_fifo_feeder #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_base(cfg_base),
    .cfg_len(cfg_len), .cfg_repeat(cfg_repeat), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_data(fifo_data), .busy(busy), .done(done), .words_sent(words_sent),
    .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Writes are logged at the negedge before the posedge that commits them.
  always @(negedge clk) if (fifo_wr_en === 1'b1) begin
    wd.push_back(fifo_data);
    wc.push_back(cyc);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [7:0] d);
    ld_en = 1; ld_addr = a[3:0]; ld_data = d;
    step;
    ld_en = 0;
  endtask

  task automatic pulse(input int b, input int l, input logic r);
    cfg_base = b[3:0]; cfg_len = l[4:0]; cfg_repeat = r; start = 1; c0 = cyc;
    step;
    start = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    step; step;
    rst = 0;
    @(negedge clk);
    n_chk++; if ({fifo_wr_en, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got %b want 000", {fifo_wr_en, busy, done}); end
    n_chk++; if (fifo_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", fifo_data); end
    n_chk++; if (words_sent !== 5'd0 || pass_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", words_sent, pass_cnt); end
    step;
  endtask

  task automatic test_basic;
    logic [7:0] ed[4] = '{8'h0F, 8'hB3, 8'h00, 8'h13};
    load(0, 8'h0F); load(1, 8'hB3); load(2, 8'h00); load(3, 8'h13);
    wd.delete(); wc.delete();
    pulse(0, 4, 0);
    n_chk++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL basic_prefetch got %b want 10", {busy, done}); end
    for (int i = 0; i < 40 && done !== 1'b1; i++) step;
    n_chk++; if (cyc !== c0 + 6) begin n_fail++; $display("FAIL basic_done_cycle got %0d want %0d", cyc - c0, 6); end
    n_chk++; if (wd.size() !== 4) begin n_fail++; $display("FAIL basic_count got %0d want 4", wd.size()); end
    if (wd.size() == 4) for (int i = 0; i < 4; i++) begin
      n_chk++; if (wd[i] !== ed[i] || wc[i] !== c0 + 2 + i) begin n_fail++; $display("FAIL basic_word%0d got %h@%0d want %h@%0d", i, wd[i], wc[i] - c0, ed[i], 2 + i); end
    end
    n_chk++; if (pass_cnt !== 16'd1 || words_sent !== 5'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_end got pc=%0d ws=%0d busy=%b want 1 0 0", pass_cnt, words_sent, busy); end
  endtask

  task automatic test_wrap;
    logic [7:0] ed[4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    load(14, 8'hA1); load(15, 8'hA2); load(0, 8'hA3); load(1, 8'hA4);
    wd.delete(); wc.delete();
    pulse(14, 4, 0);
    step; step;
    n_chk++; if (words_sent !== 5'd1) begin n_fail++; $display("FAIL wrap_ws1 got %0d want 1", words_sent); end
    step; step;
    n_chk++; if (words_sent !== 5'd3) begin n_fail++; $display("FAIL wrap_ws3 got %0d want 3", words_sent); end
    step;
    n_chk++; if (done !== 1'b1 || words_sent !== 5'd0 || pass_cnt !== 16'd1) begin n_fail++; $display("FAIL wrap_end got done=%b ws=%0d pc=%0d want 1 0 1", done, words_sent, pass_cnt); end
    n_chk++; if (wd.size() !== 4) begin n_fail++; $display("FAIL wrap_count got %0d want 4", wd.size()); end
    if (wd.size() == 4) for (int i = 0; i < 4; i++) begin
      n_chk++; if (wd[i] !== ed[i]) begin n_fail++; $display("FAIL wrap_word%0d got %h want %h", i, wd[i], ed[i]); end
    end
  endtask

  task automatic test_stall;
    int ec[6] = '{2, 3, 7, 8, 9, 10};
    for (int i = 0; i < 6; i++) load(4 + i, 8'(8'h21 + i));
    wd.delete(); wc.delete();
    pulse(4, 6, 0);
    for (int i = 0; i < 20 && wd.size() < 2; i++) step;
    for (int k = 0; k < 3; k++) begin
      fifo_full = 1;
      @(negedge clk);
      n_chk++; if (fifo_wr_en !== 1'b0 || fifo_data !== 8'h23 || words_sent !== 5'd2) begin n_fail++; $display("FAIL stall%0d got wr=%b d=%h ws=%0d want 0 23 2", k, fifo_wr_en, fifo_data, words_sent); end
      step;
    end
    fifo_full = 0;
    for (int i = 0; i < 40 && done !== 1'b1; i++) step;
    n_chk++; if (cyc !== c0 + 11) begin n_fail++; $display("FAIL stall_done_cycle got %0d want 11", cyc - c0); end
    n_chk++; if (wd.size() !== 6) begin n_fail++; $display("FAIL stall_count got %0d want 6", wd.size()); end
    if (wd.size() == 6) for (int i = 0; i < 6; i++) begin
      n_chk++; if (wd[i] !== 8'(8'h21 + i) || wc[i] !== c0 + ec[i]) begin n_fail++; $display("FAIL stall_word%0d got %h@%0d want %h@%0d", i, wd[i], wc[i] - c0, 8'(8'h21 + i), ec[i]); end
    end
  endtask

  task automatic test_repeat_abort;
    int ec[6] = '{2, 3, 4, 6, 7, 8};
    load(8, 8'h51); load(9, 8'h52); load(10, 8'h53);
    wd.delete(); wc.delete();
    pulse(8, 3, 1);
    for (int i = 0; i < 40 && pass_cnt !== 16'd2; i++) step;
    n_chk++; if (cyc !== c0 + 9 || busy !== 1'b1) begin n_fail++; $display("FAIL rep_pass2 got cyc=%0d busy=%b want 9 1", cyc - c0, busy); end
    step;
    abort = 1;
    @(negedge clk);
    n_chk++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL abort_wr got %b want 0", fifo_wr_en); end
    step;
    abort = 0;
    n_chk++; if ({busy, done} !== 2'b00 || pass_cnt !== 16'd2) begin n_fail++; $display("FAIL abort_idle got bd=%b pc=%0d want 00 2", {busy, done}, pass_cnt); end
    n_chk++; if (wd.size() !== 6) begin n_fail++; $display("FAIL rep_count got %0d want 6", wd.size()); end
    if (wd.size() == 6) for (int i = 0; i < 6; i++) begin
      n_chk++; if (wd[i] !== 8'(8'h51 + i % 3) || wc[i] !== c0 + ec[i]) begin n_fail++; $display("FAIL rep_word%0d got %h@%0d want %h@%0d", i, wd[i], wc[i] - c0, 8'(8'h51 + i % 3), ec[i]); end
    end
    step;
  endtask

  task automatic test_load_start;
    wd.delete(); wc.delete();
    ld_en = 1; ld_addr = 0; ld_data = 8'h99;
    cfg_base = 0; cfg_len = 1; cfg_repeat = 0; start = 1; c0 = cyc;
    step;
    ld_en = 0;
    repeat (10) step;
    start = 0;
    n_chk++; if (wd.size() !== 1) begin n_fail++; $display("FAIL ldst_count got %0d want 1", wd.size()); end
    if (wd.size() == 1) begin
      n_chk++; if (wd[0] !== 8'h99 || wc[0] !== c0 + 2) begin n_fail++; $display("FAIL ldst_word got %h@%0d want 99@2", wd[0], wc[0] - c0); end
    end
    n_chk++; if (done !== 1'b1 || pass_cnt !== 16'd1) begin n_fail++; $display("FAIL ldst_end got done=%b pc=%0d want 1 1", done, pass_cnt); end
    step;
  endtask

  task automatic test_load_gate;
    wd.delete(); wc.delete();
    pulse(8, 3, 0);
    ld_en = 1; ld_addr = 10; ld_data = 8'hEE;
    step; step;
    ld_en = 0;
    for (int i = 0; i < 40 && done !== 1'b1; i++) step;
    n_chk++; if (wd.size() !== 3 || wd[2] !== 8'h53) begin n_fail++; $display("FAIL gate_pass got n=%0d last=%h want 3 53", wd.size(), wd.size() == 3 ? wd[2] : 8'h00); end
    load(10, 8'hEE);
    wd.delete(); wc.delete();
    pulse(8, 3, 0);
    for (int i = 0; i < 40 && done !== 1'b1; i++) step;
    n_chk++; if (wd.size() !== 3) begin n_fail++; $display("FAIL gate_done_count got %0d want 3", wd.size()); end
    if (wd.size() == 3) begin
      n_chk++; if ({wd[0], wd[1], wd[2]} !== 24'h5152EE) begin n_fail++; $display("FAIL gate_done_data got %h%h%h want 5152ee", wd[0], wd[1], wd[2]); end
    end
  endtask

  task automatic test_rst_len0;
    for (int i = 0; i < 16; i++) begin
      automatic logic [3:0] k = 4'(i);
      load(i, {k, ~k});
    end
    wd.delete(); wc.delete();
    pulse(0, 5, 0);
    for (int i = 0; i < 20 && wd.size() < 2; i++) step;
    rst = 1;
    @(negedge clk);
    n_chk++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr got %b want 0", fifo_wr_en); end
    step;
    rst = 0;
    n_chk++; if ({busy, done} !== 2'b00 || fifo_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid got bd=%b d=%h want 00 00", {busy, done}, fifo_data); end
    n_chk++; if (words_sent !== 5'd0 || pass_cnt !== 16'd0 || wd.size() !== 2) begin n_fail++; $display("FAIL rst_mid_cnt got ws=%0d pc=%0d n=%0d want 0 0 2", words_sent, pass_cnt, wd.size()); end
    wd.delete(); wc.delete();
    pulse(0, 0, 0);
    for (int i = 0; i < 60 && done !== 1'b1; i++) step;
    n_chk++; if (cyc !== c0 + 18 || pass_cnt !== 16'd1) begin n_fail++; $display("FAIL len0_end got cyc=%0d pc=%0d want 18 1", cyc - c0, pass_cnt); end
    n_chk++; if (wd.size() !== 16) begin n_fail++; $display("FAIL len0_count got %0d want 16", wd.size()); end
    if (wd.size() == 16) for (int i = 0; i < 16; i++) begin
      automatic logic [3:0] k = 4'(i);
      n_chk++; if (wd[i] !== {k, ~k} || wc[i] !== c0 + 2 + i) begin n_fail++; $display("FAIL len0_word%0d got %h@%0d want %h@%0d", i, wd[i], wc[i] - c0, {k, ~k}, 2 + i); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_stall;
    test_repeat_abort;
    test_load_start;
    test_load_gate;
    test_rst_len0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
